axis_frame_transmitter: RTL

AXI-Stream transmitter that packs pixel groups from the frame-fetch datapath into packets for the image-processor array. Each frame is split into fixed-length packets. Each packet's TDEST is assigned round-robin across the IP_AMT processors, TLAST marks the packet end, and TID carries a wrapping frame number. It drives the slave port of the image-processor-side stream controller and sits between the frame buffer reader and the AXI-Stream fabric.

---
 rtl/axis_frame_transmitter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axis_frame_transmitter.sv
// AXI-Stream frame transmitter: splits a frame of pixel groups into fixed-length
// packets, rotates TDEST per packet, tags TID with a wrapping frame number and
// presents beats through a 2-entry skid buffer with registered m_* outputs.
module axis_frame_transmitter #(
    parameter int unsigned IP_AMT       = 2,
    parameter int unsigned IP_DATA_W    = 256,
    parameter int unsigned AXIS_TID_W   = 2,
    parameter int unsigned AXIS_TDEST_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
    parameter int unsigned AXIS_TDATA_W = IP_DATA_W,
    parameter int unsigned AXIS_TKEEP_W = AXIS_TDATA_W / 8,
    parameter int unsigned AXIS_TSTRB_W = AXIS_TDATA_W / 8,
    parameter int unsigned PKT_BEATS    = 16,
    parameter int unsigned FRAME_PKTS   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [IP_DATA_W-1:0]    pgroup_i,
    input  logic                    pgroup_valid_i,
    output logic                    pgroup_ready_o,
    output logic [AXIS_TID_W-1:0]   m_tid_o,
    output logic [AXIS_TDEST_W-1:0] m_tdest_o,
    output logic [AXIS_TDATA_W-1:0] m_tdata_o,
    output logic [AXIS_TKEEP_W-1:0] m_tkeep_o,
    output logic [AXIS_TSTRB_W-1:0] m_tstrb_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    busy_o,
    output logic                    frame_done_o
);

    localparam int unsigned BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int unsigned PKT_W  = (FRAME_PKTS > 1) ? $clog2(FRAME_PKTS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [PKT_W-1:0]        pkt_cnt;
    logic [AXIS_TDEST_W-1:0] tdest_cnt;
    logic [AXIS_TID_W-1:0]   tid_cnt;

    logic                    skid_valid;
    logic [AXIS_TDATA_W-1:0] skid_tdata;
    logic [AXIS_TDEST_W-1:0] skid_tdest;
    logic [AXIS_TID_W-1:0]   skid_tid;
    logic                    skid_tlast;

    logic push;
    logic pop;
    logic beat_last;
    logic pkt_last;
    logic frame_last_beat;
    logic drain_done;

    // Skid buffer is full exactly when its second entry is occupied.
    assign pgroup_ready_o  = (state == STREAM) && !skid_valid;
    assign push            = pgroup_valid_i && pgroup_ready_o;
    assign pop             = m_tvalid_o && m_tready_i;
    assign beat_last       = (beat_cnt == BEAT_W'(PKT_BEATS - 1));
    assign pkt_last        = (pkt_cnt == PKT_W'(FRAME_PKTS - 1));
    assign frame_last_beat = push && beat_last && pkt_last;
    // Nothing is pushed in DRAIN, so the final beat leaves when the skid entry is empty.
    assign drain_done      = (state == DRAIN) && pop && !skid_valid;
    assign frame_done_o    = drain_done;
    assign busy_o          = (state != IDLE);
    assign m_tkeep_o       = '1;
    assign m_tstrb_o       = '1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)         state_nxt = STREAM;
            STREAM:  if (frame_last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_done)      state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Beat / packet / TDEST / TID counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            pkt_cnt   <= '0;
            tdest_cnt <= '0;
            tid_cnt   <= '0;
        end else begin
            if ((state == IDLE) && start_i) begin
                beat_cnt  <= '0;
                pkt_cnt   <= '0;
                tdest_cnt <= '0;
            end else if (push) begin
                if (beat_last) begin
                    beat_cnt  <= '0;
                    pkt_cnt   <= pkt_last ? '0 : pkt_cnt + PKT_W'(1);
                    tdest_cnt <= (tdest_cnt == AXIS_TDEST_W'(IP_AMT - 1)) ? '0
                                 : tdest_cnt + AXIS_TDEST_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
            if (drain_done) tid_cnt <= tid_cnt + AXIS_TID_W'(1);
        end
    end

    // Output register plus skid entry; skid only fills when the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_o <= 1'b0;
            m_tdata_o  <= '0;
            m_tdest_o  <= '0;
            m_tid_o    <= '0;
            m_tlast_o  <= 1'b0;
            skid_valid <= 1'b0;
            skid_tdata <= '0;
            skid_tdest <= '0;
            skid_tid   <= '0;
            skid_tlast <= 1'b0;
        end else if (pop || !m_tvalid_o) begin
            if (skid_valid) begin
                m_tvalid_o <= 1'b1;
                m_tdata_o  <= skid_tdata;
                m_tdest_o  <= skid_tdest;
                m_tid_o    <= skid_tid;
                m_tlast_o  <= skid_tlast;
                skid_valid <= push;
                if (push) begin
                    skid_tdata <= AXIS_TDATA_W'(pgroup_i);
                    skid_tdest <= tdest_cnt;
                    skid_tid   <= tid_cnt;
                    skid_tlast <= beat_last;
                end
            end else begin
                m_tvalid_o <= push;
                if (push) begin
                    m_tdata_o <= AXIS_TDATA_W'(pgroup_i);
                    m_tdest_o <= tdest_cnt;
                    m_tid_o   <= tid_cnt;
                    m_tlast_o <= beat_last;
                end
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_tdata <= AXIS_TDATA_W'(pgroup_i);
            skid_tdest <= tdest_cnt;
            skid_tid   <= tid_cnt;
            skid_tlast <= beat_last;
        end
    end

endmodule
